// File: rtl/decoder_if.sv
// RV32I decoder shared codes and the decode bundle interface.
// Ports: master drives ir and reads decode fields; slave decodes.
package decoder_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [1:0] OP_TYPE_NONE = 2'd0;
  localparam logic [1:0] OP_TYPE_REG  = 2'd1;
  localparam logic [1:0] OP_TYPE_IMM  = 2'd2;
  localparam logic [1:0] OP_TYPE_PC   = 2'd3;

  localparam logic [5:0] ALU_LUI  = 6'd0;
  localparam logic [5:0] ALU_JAL  = 6'd1;
  localparam logic [5:0] ALU_JALR = 6'd2;
  localparam logic [5:0] ALU_BEQ  = 6'd3;
  localparam logic [5:0] ALU_BNE  = 6'd4;
  localparam logic [5:0] ALU_BLT  = 6'd5;
  localparam logic [5:0] ALU_BGE  = 6'd6;
  localparam logic [5:0] ALU_BLTU = 6'd7;
  localparam logic [5:0] ALU_BGEU = 6'd8;
  localparam logic [5:0] ALU_LB   = 6'd9;
  localparam logic [5:0] ALU_LH   = 6'd10;
  localparam logic [5:0] ALU_LW   = 6'd11;
  localparam logic [5:0] ALU_LBU  = 6'd12;
  localparam logic [5:0] ALU_LHU  = 6'd13;
  localparam logic [5:0] ALU_SB   = 6'd14;
  localparam logic [5:0] ALU_SH   = 6'd15;
  localparam logic [5:0] ALU_SW   = 6'd16;
  localparam logic [5:0] ALU_ADD  = 6'd17;
  localparam logic [5:0] ALU_SUB  = 6'd18;
  localparam logic [5:0] ALU_XOR  = 6'd19;
  localparam logic [5:0] ALU_OR   = 6'd20;
  localparam logic [5:0] ALU_AND  = 6'd21;
  localparam logic [5:0] ALU_SLT  = 6'd22;
  localparam logic [5:0] ALU_SLTU = 6'd23;
  localparam logic [5:0] ALU_SLL  = 6'd24;
  localparam logic [5:0] ALU_SRL  = 6'd25;
  localparam logic [5:0] ALU_SRA  = 6'd26;
  localparam logic [5:0] ALU_NOP  = 6'd63;

endpackage

interface decoder_if;
  logic [31:0] ir;
  logic [4:0]  srcreg1_num;
  logic [4:0]  srcreg2_num;
  logic [4:0]  dstreg_num;
  logic [31:0] imm;
  logic [5:0]  alucode;
  logic [1:0]  aluop1_type;
  logic [1:0]  aluop2_type;
  logic        reg_we;
  logic        is_load;
  logic        is_store;
  logic        is_halt;

  modport master (
    output ir,
    input  srcreg1_num, srcreg2_num, dstreg_num,
    input  imm, alucode, aluop1_type, aluop2_type,
    input  reg_we, is_load, is_store, is_halt
  );

  modport slave (
    input  ir,
    output srcreg1_num, srcreg2_num, dstreg_num,
    output imm, alucode, aluop1_type, aluop2_type,
    output reg_we, is_load, is_store, is_halt
  );
endinterface

// File: rtl/decoder.sv
// Combinational RV32I decoder: ir -> regs, imm, alucode, operand types.
// Ports: clk/rst (unused, no state), dif (slave: ir in, decode out).
module decoder
  import decoder_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  decoder_if.slave dif
);

  logic [31:0] ir;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        f7_zero, f7_alt;
  logic        op_ok, opi_ok, sys_ok, wr;
  logic        is_op, is_opi, is_lui, is_auipc;
  logic        is_ld, is_st, is_br, is_jal;
  logic        is_jalr, is_sys;

  logic [4:0]  s1, s2, d;
  logic [31:0] im;
  logic [5:0]  alu, rr_alu;
  logic [1:0]  t1, t2;
  logic        we, ld, st, hl;

  logic unused;
  assign unused = clk ^ rst;

  assign ir  = dif.ir;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];
  assign rd  = ir[11:7];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7],
                  ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12],
                  ir[20], ir[30:21], 1'b0};

  assign is_op    = (opc == 7'b0110011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_sys   = (opc == 7'b1110011);

  assign f7_zero = (f7 == 7'b0000000);
  assign f7_alt  = (f7 == 7'b0100000);
  // Only ADD/SUB and SRL/SRA have an alternate funct7.
  assign op_ok   = f7_zero |
                   (f7_alt & ((f3 == 3'd0) | (f3 == 3'd5)));
  // Shift immediates carry funct7 in imm[11:5]; others do not.
  assign opi_ok  = (f3 == 3'd1) ? f7_zero :
                   (f3 == 3'd5) ? (f7_zero | f7_alt) : 1'b1;
  // ECALL/EBREAK: everything zero except imm[0].
  assign sys_ok  = (ir[31:21] == 11'd0) &&
                   (ir[19:7] == 13'd0);
  assign wr      = (rd != 5'd0);

  // Register-register style opcode shared by OP and OP-IMM.
  always_comb begin
    rr_alu = ALU_ADD;
    unique case (f3)
      3'd0: rr_alu = ALU_ADD;
      3'd1: rr_alu = ALU_SLL;
      3'd2: rr_alu = ALU_SLT;
      3'd3: rr_alu = ALU_SLTU;
      3'd4: rr_alu = ALU_XOR;
      3'd5: rr_alu = ir[30] ? ALU_SRA : ALU_SRL;
      3'd6: rr_alu = ALU_OR;
      3'd7: rr_alu = ALU_AND;
    endcase
  end

  always_comb begin
    s1  = 5'd0;
    s2  = 5'd0;
    d   = 5'd0;
    im  = 32'd0;
    alu = ALU_NOP;
    t1  = OP_TYPE_NONE;
    t2  = OP_TYPE_NONE;
    we  = DISABLE;
    ld  = DISABLE;
    st  = DISABLE;
    hl  = DISABLE;
    unique case (1'b1)
      is_op: if (op_ok) begin
        s1  = rs1;
        s2  = rs2;
        d   = rd;
        alu = (f3 == 3'd0 && ir[30]) ? ALU_SUB : rr_alu;
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_REG;
        we  = wr;
      end
      is_opi: if (opi_ok) begin
        s1  = rs1;
        d   = rd;
        im  = imm_i;
        alu = rr_alu;
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_IMM;
        we  = wr;
      end
      is_lui: begin
        d   = rd;
        im  = imm_u;
        alu = ALU_LUI;
        t2  = OP_TYPE_IMM;
        we  = wr;
      end
      is_auipc: begin
        d   = rd;
        im  = imm_u;
        alu = ALU_ADD;
        t1  = OP_TYPE_IMM;
        t2  = OP_TYPE_PC;
        we  = wr;
      end
      is_ld: if (f3 != 3'd3 && f3 < 3'd6) begin
        s1  = rs1;
        d   = rd;
        im  = imm_i;
        unique case (f3)
          3'd0:    alu = ALU_LB;
          3'd1:    alu = ALU_LH;
          3'd2:    alu = ALU_LW;
          3'd4:    alu = ALU_LBU;
          default: alu = ALU_LHU;
        endcase
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_IMM;
        we  = wr;
        ld  = ENABLE;
      end
      is_st: if (f3 < 3'd3) begin
        s1  = rs1;
        s2  = rs2;
        im  = imm_s;
        unique case (f3)
          3'd0:    alu = ALU_SB;
          3'd1:    alu = ALU_SH;
          default: alu = ALU_SW;
        endcase
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_IMM;
        st  = ENABLE;
      end
      is_br: if (f3 != 3'd2 && f3 != 3'd3) begin
        s1  = rs1;
        s2  = rs2;
        im  = imm_b;
        unique case (f3)
          3'd0:    alu = ALU_BEQ;
          3'd1:    alu = ALU_BNE;
          3'd4:    alu = ALU_BLT;
          3'd5:    alu = ALU_BGE;
          3'd6:    alu = ALU_BLTU;
          default: alu = ALU_BGEU;
        endcase
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_REG;
      end
      is_jal: begin
        d   = rd;
        im  = imm_j;
        alu = ALU_JAL;
        t2  = OP_TYPE_PC;
        we  = wr;
      end
      is_jalr: if (f3 == 3'd0) begin
        s1  = rs1;
        d   = rd;
        im  = imm_i;
        alu = ALU_JALR;
        t1  = OP_TYPE_REG;
        t2  = OP_TYPE_PC;
        we  = wr;
      end
      is_sys: hl = sys_ok;
      default: ;
    endcase
  end

  assign dif.srcreg1_num = s1;
  assign dif.srcreg2_num = s2;
  assign dif.dstreg_num  = d;
  assign dif.imm         = im;
  assign dif.alucode     = alu;
  assign dif.aluop1_type = t1;
  assign dif.aluop2_type = t2;
  assign dif.reg_we      = we;
  assign dif.is_load     = ld;
  assign dif.is_store    = st;
  assign dif.is_halt     = hl;

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: spec-level model plus literal vectors.
// Drives ir after posedge, checks all outputs on the negedge.
module tb_decoder;
  import decoder_pkg::*;

  typedef struct packed {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic [31:0] imm;
    logic [5:0]  alu;
    logic [1:0]  t1;
    logic [1:0]  t2;
    logic        we;
    logic        ld;
    logic        st;
    logic        hl;
  } exp_t;

  localparam logic [5:0] RTAB [8] = '{ALU_ADD, ALU_SLL, ALU_SLT,
    ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
  localparam logic [5:0] LTAB [8] = '{ALU_LB, ALU_LH, ALU_LW,
    ALU_NOP, ALU_LBU, ALU_LHU, ALU_NOP, ALU_NOP};
  localparam logic [5:0] STAB [8] = '{ALU_SB, ALU_SH, ALU_SW,
    ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP, ALU_NOP};
  localparam logic [5:0] BTAB [8] = '{ALU_BEQ, ALU_BNE, ALU_NOP,
    ALU_NOP, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU};

  localparam logic [1:0] N = OP_TYPE_NONE;
  localparam logic [1:0] R = OP_TYPE_REG;
  localparam logic [1:0] I = OP_TYPE_IMM;
  localparam logic [1:0] P = OP_TYPE_PC;

  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;
  bit   chk_en  = 1'b0;

  always #5 clk = ~clk;

  decoder_if dif ();

  decoder dut (
    .clk (clk),
    .rst (rst),
    .dif (dif)
  );

  function automatic exp_t mk(
    input logic [4:0] s1, input logic [4:0] s2,
    input logic [4:0] d, input logic [31:0] imm,
    input logic [5:0] alu, input logic [1:0] t1,
    input logic [1:0] t2, input logic we, input logic ld,
    input logic st, input logic hl);
    exp_t e;
    e = '{s1, s2, d, imm, alu, t1, t2, we, ld, st, hl};
    return e;
  endfunction

  function automatic exp_t nop_v();
    return mk(5'd0, 5'd0, 5'd0, 32'd0, ALU_NOP, N, N,
              1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic exp_t model(input logic [31:0] w);
    exp_t        e;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] ii, is, ib, iu, ij;
    logic [5:0]  a;
    logic        wr;
    e   = nop_v();
    rd  = w[11:7];
    rs1 = w[19:15];
    rs2 = w[24:20];
    f3  = w[14:12];
    f7  = w[31:25];
    wr  = (rd != 5'd0);
    ii  = 32'($signed(w[31:20]));
    is  = 32'($signed({w[31:25], w[11:7]}));
    ib  = 32'($signed({w[31], w[7], w[30:25], w[11:8]})) * 32'sd2;
    iu  = w & 32'hFFFF_F000;
    ij  = 32'($signed({w[31], w[19:12], w[20], w[30:21]})) * 32'sd2;
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00)
          e = mk(rs1, rs2, rd, 32'd0, RTAB[f3], R, R,
                 wr, 1'b0, 1'b0, 1'b0);
        else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
          a = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
          e = mk(rs1, rs2, rd, 32'd0, a, R, R,
                 wr, 1'b0, 1'b0, 1'b0);
        end
      end
      7'h13: begin
        a = (f3 == 3'd5 && w[30]) ? ALU_SRA : RTAB[f3];
        if (!(f3 == 3'd1 && f7 != 7'h00) &&
            !(f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20))
          e = mk(rs1, 5'd0, rd, ii, a, R, I,
                 wr, 1'b0, 1'b0, 1'b0);
      end
      7'h37: e = mk(5'd0, 5'd0, rd, iu, ALU_LUI, N, I,
                    wr, 1'b0, 1'b0, 1'b0);
      7'h17: e = mk(5'd0, 5'd0, rd, iu, ALU_ADD, I, P,
                    wr, 1'b0, 1'b0, 1'b0);
      7'h03: if (LTAB[f3] != ALU_NOP)
        e = mk(rs1, 5'd0, rd, ii, LTAB[f3], R, I,
               wr, 1'b1, 1'b0, 1'b0);
      7'h23: if (STAB[f3] != ALU_NOP)
        e = mk(rs1, rs2, 5'd0, is, STAB[f3], R, I,
               1'b0, 1'b0, 1'b1, 1'b0);
      7'h63: if (BTAB[f3] != ALU_NOP)
        e = mk(rs1, rs2, 5'd0, ib, BTAB[f3], R, R,
               1'b0, 1'b0, 1'b0, 1'b0);
      7'h6f: e = mk(5'd0, 5'd0, rd, ij, ALU_JAL, N, P,
                    wr, 1'b0, 1'b0, 1'b0);
      7'h67: if (f3 == 3'd0)
        e = mk(rs1, 5'd0, rd, ii, ALU_JALR, R, P,
               wr, 1'b0, 1'b0, 1'b0);
      7'h73: if (w == 32'h0000_0073 || w == 32'h0010_0073)
        e.hl = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t got();
    return mk(dif.srcreg1_num, dif.srcreg2_num, dif.dstreg_num,
              dif.imm, dif.alucode, dif.aluop1_type,
              dif.aluop2_type, dif.reg_we, dif.is_load,
              dif.is_store, dif.is_halt);
  endfunction

  task automatic check(input string nm, input logic [31:0] w,
                       input exp_t act, input exp_t req);
    n_total++;
    if (act === req) n_pass++;
    else
      $display("FAIL %s ir=%h got=%h required=%h",
               nm, w, act, req);
  endtask

  always @(negedge clk)
    if (chk_en) check("model", dif.ir, got(), model(dif.ir));

  task automatic apply(input logic [31:0] w);
    @(posedge clk);
    dif.ir = w;
  endtask

  logic [31:0] lit_ir  [14];
  exp_t        lit_exp [14];
  logic [6:0]  opcs    [12];
  logic [31:0] bases   [5];
  logic [31:0] w;

  initial begin
    lit_ir[0]  = 32'h00b50633;
    lit_exp[0] = mk(10, 11, 12, 0, ALU_ADD, R, R, 1, 0, 0, 0);
    lit_ir[1]  = 32'h40b5d7b3;
    lit_exp[1] = mk(11, 11, 15, 0, ALU_SRA, R, R, 1, 0, 0, 0);
    lit_ir[2]  = 32'hfff00513;
    lit_exp[2] = mk(0, 0, 10, 32'hffffffff, ALU_ADD, R, I,
                    1, 0, 0, 0);
    lit_ir[3]  = 32'h4015d793;
    lit_exp[3] = mk(11, 0, 15, 1025, ALU_SRA, R, I, 1, 0, 0, 0);
    lit_ir[4]  = 32'h808805b7;
    lit_exp[4] = mk(0, 0, 11, 32'h80880000, ALU_LUI, N, I,
                    1, 0, 0, 0);
    lit_ir[5]  = 32'h00000817;
    lit_exp[5] = mk(0, 0, 16, 0, ALU_ADD, I, P, 1, 0, 0, 0);
    lit_ir[6]  = 32'h00b510a3;
    lit_exp[6] = mk(10, 11, 0, 1, ALU_SH, R, I, 0, 0, 1, 0);
    lit_ir[7]  = 32'h00354683;
    lit_exp[7] = mk(10, 0, 13, 3, ALU_LBU, R, I, 1, 1, 0, 0);
    lit_ir[8]  = 32'hfec584e3;
    lit_exp[8] = mk(11, 12, 0, -32'sd24, ALU_BEQ, R, R,
                    0, 0, 0, 0);
    lit_ir[9]  = 32'hf8e572e3;
    lit_exp[9] = mk(10, 14, 0, -32'sd124, ALU_BGEU, R, R,
                    0, 0, 0, 0);
    lit_ir[10]  = 32'h008000ef;
    lit_exp[10] = mk(0, 0, 1, 8, ALU_JAL, N, P, 1, 0, 0, 0);
    lit_ir[11]  = 32'h00c0006f;
    lit_exp[11] = mk(0, 0, 0, 12, ALU_JAL, N, P, 0, 0, 0, 0);
    lit_ir[12]  = 32'h00000073;
    lit_exp[12] = mk(0, 0, 0, 0, ALU_NOP, N, N, 0, 0, 0, 1);
    lit_ir[13]  = 32'hffffffff;
    lit_exp[13] = nop_v();

    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23,
             7'h63, 7'h6f, 7'h67, 7'h73, 7'h0f, 7'h7f};
    bases = '{32'h00b50600, 32'h40b5d780, 32'hfec584e0,
              32'h00000000, 32'h8015d000};

    rst    = 1'b1;
    dif.ir = 32'h0000_0000;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 check("reset_nop", dif.ir, got(), nop_v());
    @(posedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      apply(lit_ir[i]);
      @(negedge clk);
      #1;
      check($sformatf("lit%0d", i), lit_ir[i], got(), lit_exp[i]);
      check($sformatf("pin%0d", i), lit_ir[i],
            model(lit_ir[i]), lit_exp[i]);
    end

    for (int o = 0; o < 12; o++)
      for (int b = 0; b < 5; b++)
        for (int f = 0; f < 8; f++) begin
          w = bases[b];
          w[14:12] = 3'(f);
          w[6:0]   = opcs[o];
          apply(w);
        end

    apply(32'h00100073);
    apply(32'h30002573);
    apply(32'h0ff0000f);
    apply(32'h00b50033);
    apply(32'h02b50633);
    apply(32'h00159513);
    apply(32'h02159513);

    for (int k = 0; k < 300; k++) begin
      w = $urandom;
      if (k % 2 == 0) w[6:0] = opcs[$urandom_range(0, 11)];
      apply(w);
    end

    @(negedge clk);
    #1 chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/decoder.md
Name: decoder

Overview:
- Combinational RV32I instruction decoder in the execute datapath front end.
- Takes one 32-bit instruction word and produces:
  - register numbers,
  - sign-extended immediate,
  - ALU operation code,
  - operand source selects,
  - write-enable, load, store and halt flags.
- All ALU_* and OP_TYPE_* codes come from the shared define header. ENABLE=1, DISABLE=0.

Parameters:
- None.

Ports:
- clk  input  1  system clock; unused by the decode path, present for interface uniformity.
- rst  input  1  reset, synchronous and active-high; no internal state, so it has no effect on outputs.
- ir  input  32  instruction word.
- srcreg1_num  output  5  rs1 number.
- srcreg2_num  output  5  rs2 number.
- dstreg_num  output  5  rd number.
- imm  output  32  decoded, sign-extended immediate.
- alucode  output  6  ALU_* operation code.
- aluop1_type  output  2  operand-1 source (OP_TYPE_NONE/REG/IMM/PC).
- aluop2_type  output  2  operand-2 source.
- reg_we  output  1  register write enable.
- is_load  output  1  load instruction.
- is_store  output  1  store instruction.
- is_halt  output  1  halt request.

Behaviour:
- General:
  - Purely combinational; outputs valid in the same delta as ir; zero-cycle latency.
  - No reset value is needed: outputs are a pure function of ir at all times, including during rst.
  - Unused register fields output 0.
  - reg_we is forced to 0 whenever rd=0, for all writing formats.
  - Immediate formats:
    - I: sext(ir[31:20]).
    - S: sext({ir[31:25],ir[11:7]}).
    - B: sext({ir[31],ir[7],ir[30:25],ir[11:8],1'b0}).
    - U: {ir[31:12],12'b0}.
    - J: sext({ir[31],ir[19:12],ir[20],ir[30:21],1'b0}).
- OP (0110011):
  - src1=rs1, src2=rs2, dst=rd, imm=0.
  - aluop1/aluop2 = REG/REG, we=1.
  - alucode by funct3 and ir[30]:
    - ADD/SUB
    - SLL
    - SLT
    - SLTU
    - XOR
    - SRL/SRA
    - OR
    - AND
- OP-IMM (0010011):
  - src1=rs1, src2=0, dst=rd, imm=I-format, REG/IMM, we=1.
  - Opcodes: ADD, SLT, SLTU, XOR, OR, AND, SLL, SRL/SRA (selected by ir[30]).
  - Shift imm is the full I-immediate; the ALU uses imm[4:0]. Example: SRAI shamt 1 gives imm=1025.
- LUI (0110111): src 0/0, dst=rd, U-imm, ALU_LUI, NONE/IMM, we=1.
- AUIPC (0010111): src 0/0, dst=rd, U-imm, ALU_ADD, IMM/PC, we=1.
- LOAD (0000011):
  - src1=rs1, src2=0, dst=rd, I-imm, REG/IMM, we=1, is_load=1.
  - funct3 0/1/2/4/5 maps to ALU_LB/LH/LW/LBU/LHU.
- STORE (0100011):
  - src1=rs1, src2=rs2, dst=0, S-imm, REG/IMM, we=0, is_store=1.
  - funct3 0/1/2 maps to ALU_SB/SH/SW.
- BRANCH (1100011):
  - src1=rs1, src2=rs2, dst=0, B-imm, REG/REG, we=0.
  - funct3 0/1/4/5/6/7 maps to ALU_BEQ/BNE/BLT/BGE/BLTU/BGEU.
- JAL (1101111): src 0/0, dst=rd, J-imm, ALU_JAL, NONE/PC, we=(rd≠0).
- JALR (1100111, funct3=0): src1=rs1, dst=rd, I-imm, ALU_JALR, REG/PC, we=(rd≠0).
- SYSTEM (1110011, ECALL/EBREAK): is_halt=1, all other outputs take NOP values.
- NOP values (undefined opcode, reserved funct3/funct7, FENCE):
  - All register numbers 0, imm=0.
  - alucode=ALU_NOP.
  - aluop1/aluop2 = NONE/NONE.
  - reg_we, is_load, is_store = 0.
  - is_halt=0 except for SYSTEM.

Test Plan:
- R-type:
  - 0x00b50633 → 10,11,12, imm 0, ALU_ADD, REG/REG, we=1.
  - 0x40b5d7b3 → 11,11,15, ALU_SRA.
- I-type:
  - 0xfff00513 → 0,0,10, imm 0xffffffff, ALU_ADD, REG/IMM, we=1.
  - 0x4015d793 → 11,0,15, imm 1025, ALU_SRA.
- U-type:
  - 0x808805b7 → dst 11, imm 0x80880000, ALU_LUI, NONE/IMM.
  - 0x00000817 → dst 16, imm 0, ALU_ADD, IMM/PC.
- Memory:
  - 0x00b510a3 → 10,11,0, imm 1, ALU_SH, REG/IMM, we=0, is_store=1.
  - 0x00354683 → 10,0,13, imm 3, ALU_LBU, we=1, is_load=1.
- Branch:
  - 0xfec584e3 → 11,12,0, imm −24, ALU_BEQ, REG/REG, we=0.
  - 0xf8e572e3 → 10,14, imm −124, ALU_BGEU.
- JAL:
  - 0x008000ef → dst 1, imm 8, ALU_JAL, NONE/PC, we=1.
  - 0x00c0006f → dst 0, imm 12, we=0.
  - Also 0x00000073 → is_halt=1; 0xffffffff → NOP values.
